// File: rtl/square_motion_controller.sv
// Vertical-motion controller for the player square: start drop, landing,
// wait for release, sound-driven motion, game over and restart.
// Y only moves on the frame TICK strobe; state changes are evaluated every clock.
module square_motion_controller #(
    parameter int COORD_W    = 10,
    parameter int LEVEL_W    = 3,
    parameter int NUM_LEVELS = 5,
    parameter int Y_START    = 20,
    parameter int Y_LAND     = 180,
    parameter int Y_TOP      = 42,
    parameter int Y_BOTTOM   = 492,
    parameter int DROP_STEP  = 2,
    parameter int FALL_STEP  = 4,
    parameter int UP_BASE    = 1,
    parameter int UP_INC     = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               TICK,
    input  logic               DROP_START,
    input  logic               FREE_MOVE,
    input  logic               PAUSE,
    input  logic               GAME_OVER,
    input  logic               RESTART,
    input  logic [LEVEL_W-1:0] SOUND_LEVEL,
    output logic [COORD_W-1:0] SQUARE_Y_COORDINATE,
    output logic               DROP_FINISH,
    output logic               AT_TOP,
    output logic               AT_BOTTOM,
    output logic [2:0]         STATE
);

    // One extra bit of headroom so sums/differences never wrap before clamping.
    localparam int EXT_W = COORD_W + 1;

    localparam logic [COORD_W-1:0] Y_START_C  = COORD_W'(Y_START);
    localparam logic [COORD_W-1:0] Y_LAND_C   = COORD_W'(Y_LAND);
    localparam logic [COORD_W-1:0] Y_TOP_C    = COORD_W'(Y_TOP);
    localparam logic [COORD_W-1:0] Y_BOTTOM_C = COORD_W'(Y_BOTTOM);

    localparam logic [EXT_W-1:0] Y_LAND_E    = EXT_W'(Y_LAND);
    localparam logic [EXT_W-1:0] Y_TOP_E     = EXT_W'(Y_TOP);
    localparam logic [EXT_W-1:0] Y_BOTTOM_E  = EXT_W'(Y_BOTTOM);
    localparam logic [EXT_W-1:0] DROP_STEP_E = EXT_W'(DROP_STEP);
    localparam logic [EXT_W-1:0] FALL_STEP_E = EXT_W'(FALL_STEP);
    localparam logic [EXT_W-1:0] UP_BASE_E   = EXT_W'(UP_BASE);
    localparam logic [EXT_W-1:0] UP_INC_E    = EXT_W'(UP_INC);

    localparam logic [LEVEL_W-1:0] NUM_LEVELS_C = LEVEL_W'(NUM_LEVELS);
    localparam logic [LEVEL_W-1:0] ONE_LEVEL_C  = LEVEL_W'(1);

    // Encodings are fixed because the renderer decodes STATE directly.
    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_DROP = 3'b001,
        S_WAIT = 3'b011,
        S_MOVE = 3'b010,
        S_OVER = 3'b110
    } state_t;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               drop_finish_q, drop_finish_d;
    logic               at_top_q, at_top_d;
    logic               at_bottom_q, at_bottom_d;

    logic [LEVEL_W-1:0] level_clamped;
    logic [EXT_W-1:0]   y_ext, up_step, drop_sum, fall_sum, up_diff;
    logic [COORD_W-1:0] drop_y, fall_y, up_y;
    logic               move_en;

    // Candidate next-Y values for each motion mode, clamped to their limits.
    always_comb begin
        level_clamped = (SOUND_LEVEL > NUM_LEVELS_C) ? NUM_LEVELS_C : SOUND_LEVEL;
        y_ext         = {1'b0, y_q};
        // Level 0 never selects this path, so the wrap of (0 - 1) is harmless.
        up_step       = UP_BASE_E + UP_INC_E * EXT_W'(level_clamped - ONE_LEVEL_C);
        drop_sum      = y_ext + DROP_STEP_E;
        fall_sum      = y_ext + FALL_STEP_E;
        up_diff       = y_ext - up_step;
        drop_y        = (drop_sum > Y_LAND_E)   ? Y_LAND_C   : drop_sum[COORD_W-1:0];
        fall_y        = (fall_sum > Y_BOTTOM_E) ? Y_BOTTOM_C : fall_sum[COORD_W-1:0];
        // A set top bit means the subtraction went negative.
        up_y          = (up_diff[COORD_W] || (up_diff < Y_TOP_E)) ? Y_TOP_C
                                                                  : up_diff[COORD_W-1:0];
        move_en       = TICK && !PAUSE;
    end

    // Next-state, next-Y and flag computation; flags follow the next values.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                y_d = Y_START_C;
                if (DROP_START && !PAUSE) state_d = S_DROP;
            end
            S_DROP: begin
                if ((y_q == Y_LAND_C) && !PAUSE) state_d = S_WAIT;
                if (move_en) y_d = drop_y;
            end
            S_WAIT: begin
                if (GAME_OVER)                  state_d = S_OVER;
                else if (FREE_MOVE && !PAUSE)   state_d = S_MOVE;
            end
            S_MOVE: begin
                if (GAME_OVER) state_d = S_OVER;
                if (move_en) y_d = (SOUND_LEVEL == '0) ? fall_y : up_y;
            end
            S_OVER: begin
                if (RESTART) begin
                    state_d = S_IDLE;
                    y_d     = Y_START_C;
                end
            end
            default: begin
                state_d = S_IDLE;
                y_d     = Y_START_C;
            end
        endcase
        drop_finish_d = (state_d == S_WAIT);
        at_top_d      = (y_d == Y_TOP_C);
        at_bottom_d   = (y_d == Y_BOTTOM_C);
    end

    // State, Y and status registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            y_q           <= Y_START_C;
            drop_finish_q <= 1'b0;
            at_top_q      <= 1'b0;
            at_bottom_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            y_q           <= y_d;
            drop_finish_q <= drop_finish_d;
            at_top_q      <= at_top_d;
            at_bottom_q   <= at_bottom_d;
        end
    end

    assign SQUARE_Y_COORDINATE = y_q;
    assign DROP_FINISH         = drop_finish_q;
    assign AT_TOP              = at_top_q;
    assign AT_BOTTOM           = at_bottom_q;
    assign STATE               = state_q;

endmodule
